// File: rtl/bit_serial_alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU: opcode constants, FSM encoding
// and the carry-in selection used when an operation is accepted.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOR  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Subtraction is a + ~b + 1, so only SUB starts with the carry set.
  function automatic logic cin_for_op(input logic [2:0] op);
    cin_for_op = (op == OP_SUB) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/bit_serial_alu_ctrl_slice.sv
// Purely combinational 1-bit ALU slice; carry is only meaningful for ADD/SUB
// and is forced low for every other opcode.
module alu_slice_1_bit
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       out,
  output logic       cout
);

  logic w_b_eff;
  logic w_half;
  logic w_sum;
  logic w_carry;

  assign w_b_eff = (op == OP_SUB) ? ~b : b;
  assign w_half  = a ^ w_b_eff;
  assign w_sum   = w_half ^ cin;
  assign w_carry = (a & w_b_eff) | (cin & w_half);

  always_comb begin
    out  = 1'b0;
    cout = 1'b0;
    case (op)
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_NOR:  out = ~(a | b);
      OP_XOR:  out = a ^ b;
      OP_ADD,
      OP_SUB: begin
        out  = w_sum;
        cout = w_carry;
      end
      OP_PASS: out = a;
      default: begin
        out  = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: feeds one operand bit pair per clock, LSB first,
// through a single 1-bit slice and assembles the result by right shifting.
module bit_serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_op;
  logic               r_carry;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_out;
  logic               r_carry_out;
  logic               r_zero;

  logic               w_accept;
  logic               w_last;
  logic               w_slice_out;
  logic               w_slice_cout;
  logic [WIDTH-1:0]   w_shift_nxt;

  assign w_accept    = start & ((r_state == IDLE) | (r_state == DONE));
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_shift_nxt = {w_slice_out, r_shift[WIDTH-1:1]};

  alu_slice_1_bit u_slice (
    .a    (r_a[r_cnt]),
    .b    (r_b[r_cnt]),
    .cin  (r_carry),
    .op   (r_op),
    .out  (w_slice_out),
    .cout (w_slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        if (start) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-bit iteration and final result registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= OP_AND;
      r_carry     <= 1'b0;
      r_shift     <= '0;
      r_out       <= '0;
      r_carry_out <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_a     <= a;
      r_b     <= b;
      r_op    <= op;
      r_carry <= cin_for_op(op);
      r_shift <= '0;
    end else if (r_state == RUN) begin
      r_shift <= w_shift_nxt;
      r_carry <= w_slice_cout;
      if (w_last) begin
        r_cnt       <= '0;
        r_out       <= w_shift_nxt;
        r_carry_out <= w_slice_cout;
        r_zero      <= (w_shift_nxt == '0);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign out       = r_out;
  assign carry_out = r_carry_out;
  assign zero      = r_zero;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed, table-driven bench for bit_serial_alu_ctrl (WIDTH=8) plus
// hand-written sequences for start-while-busy and reset mid-operation.
module tb_bit_serial_alu_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             carry_out;
  logic             zero;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic             b2b;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_out;
    logic             exp_cout;
    logic             exp_zero;
  } vec_t;

  vec_t vecs[12];

  bit_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .carry_out (carry_out),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: requests one op, returns at the negedge where done is seen.
  task automatic do_op(input logic [2:0] t_op, input logic [WIDTH-1:0] t_a,
                       input logic [WIDTH-1:0] t_b, output int busy_cycles,
                       output logic got_done);
    start = 1'b1; op = t_op; a = t_a; b = t_b;
    @(negedge clk);
    start = 1'b0; op = 3'b000; a = '0; b = '0;
    busy_cycles = 0;
    got_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int          bc;
    logic        gd;
    int          pulses;
    logic [WIDTH-1:0] seen_out;

    vecs[0]  = '{1'b0, 3'b100, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 3'b101, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 3'b101, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 3'b010, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 3'b011, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 3'b111, 8'hAB, 8'hCD, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 3'b110, 8'hAB, 8'h00, 8'hAB, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'b001, 8'h81, 8'h42, 8'hC3, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'b100, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'b101, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 3'b101, 8'h33, 8'h33, 8'h00, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_out", {24'd0, out}, 32'd0);
    chk("reset_cout", {31'd0, carry_out}, 32'd0);
    chk("reset_zero", {31'd0, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, bc, gd);
      chk($sformatf("v%0d_done", i), {31'd0, gd}, 32'd1);
      chk($sformatf("v%0d_busy_cycles", i), bc, WIDTH);
      chk($sformatf("v%0d_out", i), {24'd0, out}, {24'd0, vecs[i].exp_out});
      chk($sformatf("v%0d_cout", i), {31'd0, carry_out}, {31'd0, vecs[i].exp_cout});
      chk($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].exp_zero});
      if (i == 11 || !vecs[i+1].b2b) begin
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
        chk($sformatf("v%0d_idle_busy", i), {31'd0, busy}, 32'd0);
        chk($sformatf("v%0d_out_held", i), {24'd0, out}, {24'd0, vecs[i].exp_out});
      end
    end

    // start re-asserted mid-RUN with a different operand must be ignored
    start = 1'b1; op = 3'b100; a = 8'h10; b = 8'h20;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'h11; op = 3'b100;
    @(negedge clk);
    start = 1'b0; a = '0;
    pulses = 0;
    seen_out = '0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        pulses++;
        seen_out = out;
      end
      @(negedge clk);
    end
    chk("ignore_start_pulses", pulses, 32'd1);
    chk("ignore_start_out", {24'd0, seen_out}, 32'h30);

    // asynchronous reset in the middle of RUN
    start = 1'b1; op = 3'b100; a = 8'h0F; b = 8'h01;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_out", {24'd0, out}, 32'd0);
    chk("midrst_zero", {31'd0, zero}, 32'd0);
    chk("midrst_cout", {31'd0, carry_out}, 32'd0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) pulses++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("midrst_no_done", pulses, 32'd0);
    do_op(3'b100, 8'h0F, 8'h01, bc, gd);
    chk("postrst_done", {31'd0, gd}, 32'd1);
    chk("postrst_busy_cycles", bc, WIDTH);
    chk("postrst_out", {24'd0, out}, 32'h10);
    chk("postrst_cout", {31'd0, carry_out}, 32'd0);
    chk("postrst_zero", {31'd0, zero}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serial_alu_ctrl.md
Name: bit_serial_alu_ctrl

Overview:
- Sequencer that runs a WIDTH-bit ALU operation through one 1-bit ALU slice, LSB first, one bit per clock.
- Captures the operands and opcode on start.
- Iterates a bit counter and carries the carry/borrow between slices.
- Shifts each slice output into the result register, then reports the result with a one-cycle done pulse.
- Sits between the instruction/issue logic and the bit-slice datapath. It is the area-minimal alternative to the parallel ripple ALU.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- CNT_W, $clog2(WIDTH), bit-counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an operation; accepted only in IDLE or DONE.
- op  input  3  opcode, sampled with start.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while an operation is in progress (RUN).
- done  output  1  one-cycle pulse: result valid.
- out  output  WIDTH  result, held until next accepted start.
- carry_out  output  1  final carry (ADD) / not-borrow (SUB); 0 for logic ops.
- zero  output  1  out == 0, valid with done and held.

Behaviour:
- Interface: one clock clk. Reset rst_n is asynchronous and active-low.
- Reset (async, any state): state=IDLE, counter=0, busy=0, done=0, out=0, carry_out=0, zero=0, internal carry=0.
- Opcodes:
  - 000 AND, 001 OR, 010 NOR, 011 XOR.
  - 100 ADD (carry-in 0).
  - 101 SUB (slice sees ~b bit, carry-in 1).
  - 110 PASS A.
  - 111 reserved: result forced to 0, carry_out 0.
- States:
  - IDLE: busy=0. start=1 at edge → latch a, b, op; counter=0; carry=cin(op); state→RUN.
  - RUN: busy=1. Each edge:
    - slice evaluates bit[counter] of the latched operands with the stored carry;
    - slice out bit shifted into result MSB (result >> 1); carry register updated;
    - counter+1.
    - When counter==WIDTH-1 at the edge: state→DONE; out, carry_out and zero are registered from the final shifted value.
  - DONE: done=1, busy=0, for exactly one cycle.
    - start=1 → same capture as IDLE, state→RUN (back-to-back, no bubble).
    - Otherwise state→IDLE.
- Latency: the accepting edge is E0. Bits are processed at E1..E_WIDTH. done is high in the cycle after E_WIDTH. Throughput is one operation per WIDTH+1 cycles.
- start while RUN: ignored, no effect on latched operands. a, b and op may change freely after acceptance.
- out/zero/carry_out: update only on entry to DONE. They hold their value through IDLE and the next RUN until the following DONE.
- carry_out for logic/PASS/reserved ops: 0.
- Counter wrap: counter never exceeds WIDTH-1; it is cleared on every accept.
- Reset mid-RUN: operation aborted immediately, no done pulse, all outputs return to reset values.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_AND..OP_RSVD (3-bit);
  - state encoding IDLE/RUN/DONE (2-bit).
- Sub-module alu_slice_1_bit: purely combinational 1-bit slice.
  - Inputs: a, b, cin, op[2:0].
  - Outputs: out, cout.
  - Built from the team's existing gate-level 1-bit primitives (AND/OR/NOR/XOR/full-adder).
- The controller owns all registers and the FSM.

Test Plan:
- WIDTH=8, op=100, a=0xFF, b=0x01, start 1 cycle → busy high 8 cycles; done pulse in cycle after E8; out=0x00, carry_out=1, zero=1.
- op=101, a=0x05, b=0x07 → out=0xFE, carry_out=0 (borrow), zero=0; then op=101, a=0x07, b=0x05 back-to-back in DONE → out=0x02, carry_out=1, no idle cycle between.
- op=010 (NOR), a=0xF0, b=0x0F → out=0x00, zero=1, carry_out=0; op=011 (XOR) a=0xA5, b=0xFF → out=0x5A.
- start re-asserted with a=0x11 at cycle 3 of RUN of ADD 0x10+0x20 → ignored; out=0x30, a single done pulse.
- rst_n low at cycle 4 of RUN → busy/done/out/zero/carry_out immediately 0, no done; next start after release completes normally.
- op=111, a=0xAB, b=0xCD → out=0x00, carry_out=0, zero=1; op=110 a=0xAB → out=0xAB.
